// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam int DEF_BITS     = 64;
    localparam int DEF_MEM_SIZE = 16;
    localparam int DEF_MEM_LAT  = 2;

    // Wide enough for MemLat-1 with MemLat up to 4.
    localparam int LAT_CNT_W    = 3;

endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency down-counter used while the arbiter waits on memory data.
// Loaded once per read, counts down to zero and then holds there.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for one shared
// memory port with fixed read latency. One access in flight at a time.
// Optional macro MEM_ARB_RR_EN: round-robin between requesters instead of
// fixed load/store-over-fetch priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int Bits    = DEF_BITS,
    parameter  int MemSize = DEF_MEM_SIZE,
    parameter  int MemLat  = DEF_MEM_LAT,
    localparam int AW      = $clog2(MemSize)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [Bits-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [Bits-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [Bits-1:0] ls_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [Bits-1:0] mem_wdata,
    input  logic [Bits-1:0] mem_rdata,
    output logic            busy
);

    state_t          state;
    req_id_t         id_q;
    req_id_t         win;
    logic [AW-1:0]   addr_q;
    logic [Bits-1:0] wdata_q;
    logic [Bits-1:0] rdata_q;
    logic            mem_en_q;
    logic            mem_we_q;
    logic            rvalid_q;
    logic            grant_fire;
    logic            lat_zero;

    assign grant_fire = (state == IDLE) && (if_req || ls_req);

`ifdef MEM_ARB_RR_EN
    req_id_t last_q;

    // Round-robin pick: on contention, favour whoever was not granted last.
    always_comb begin
        win = REQ_LS;
        if (if_req && ls_req) begin
            win = (last_q == REQ_LS) ? REQ_IF : REQ_LS;
        end else if (if_req) begin
            win = REQ_IF;
        end
    end

    // Remember the most recent winner; reset to fetch so load/store goes first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_IF;
        end else if (grant_fire) begin
            last_q <= win;
        end
    end
`else
    // Fixed priority: load/store always beats fetch.
    always_comb begin
        win = ls_req ? REQ_LS : REQ_IF;
    end
`endif

    // Loaded on the ACCESS cycle of a read so it holds MemLat-1 on WAIT entry.
    mem_lat_counter #(
        .W(LAT_CNT_W)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == ACCESS) && !mem_we_q),
        .load_val (LAT_CNT_W'(MemLat - 1)),
        .dec      (state == WAIT),
        .zero     (lat_zero)
    );

    // Main FSM: capture winner, issue one memory cycle, wait, respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            id_q     <= REQ_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        id_q     <= win;
                        mem_en_q <= 1'b1;
                        if (win == REQ_LS) begin
                            mem_we_q <= ls_we;
                            addr_q   <= ls_addr;
                            wdata_q  <= ls_wdata;
                        end else begin
                            mem_we_q <= 1'b0;
                            addr_q   <= if_addr;
                            wdata_q  <= '0;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state    <= mem_we_q ? IDLE : WAIT;
                end
                WAIT: begin
                    if (lat_zero) begin
                        rdata_q  <= mem_rdata;
                        rvalid_q <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grants are combinational in IDLE; gated by reset so they drop at once.
    assign if_gnt    = rst && grant_fire && (win == REQ_IF);
    assign ls_gnt    = rst && grant_fire && (win == REQ_LS);

    assign if_rvalid = rvalid_q && (id_q == REQ_IF);
    assign ls_rvalid = rvalid_q && (id_q == REQ_LS);
    assign if_rdata  = rdata_q;
    assign ls_rdata  = rdata_q;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner
// sequences (contention, reset mid-read, requests while busy) and a random
// phase checked against a transaction-timing reference model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam int NR  = 1500;
    localparam int NS  = NR + LAT + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [3:0]  if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_addr = '0;
    logic [63:0] ls_wdata = '0;
    logic        ls_gnt, ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.Bits(64), .MemSize(16), .MemLat(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory device: preloaded during reset, writes on en&we, reads return after LAT cycles.
    logic [63:0] dev_mem [16];
    logic [63:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) dev_mem[i] <= (i == 3) ? 64'hA5 : 64'h1000 + 64'(i);
        end else if (mem_en && mem_we) begin
            dev_mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? dev_mem[mem_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk1({tag, "_ls_gnt"}, ls_gnt, 1'b0);
        chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        chk1({tag, "_ls_rvalid"}, ls_rvalid, 1'b0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_rdata"}, if_rdata, 64'd0);
        chk({tag, "_ls_rdata"}, ls_rdata, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One complete transaction started from IDLE, with cycle-exact checks.
    task automatic do_txn(input string tag, input logic is_ls, input logic we,
                          input logic [3:0] addr, input logic [63:0] wd, input logic [63:0] rd);
        @(negedge clk);
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        chk1({tag, "_gnt"}, is_ls ? ls_gnt : if_gnt, 1'b1);
        chk1({tag, "_other_gnt"}, is_ls ? if_gnt : ls_gnt, 1'b0);
        chk1({tag, "_no_rvalid_T"}, if_rvalid | ls_rvalid, 1'b0);
        chk1({tag, "_idle_busy"}, busy, 1'b0);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        #1;
        chk1({tag, "_mem_en"}, mem_en, 1'b1);
        chk1({tag, "_mem_we"}, mem_we, we);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
        if (we) chk({tag, "_mem_wdata"}, mem_wdata, wd);
        if (!we) begin
            for (int k = 2; k <= LAT + 1; k++) begin
                @(negedge clk); #1;
                chk1({tag, "_wait_en"}, mem_en, 1'b0);
                chk1({tag, "_wait_rvalid"}, if_rvalid | ls_rvalid, 1'b0);
                chk1({tag, "_wait_busy"}, busy, 1'b1);
            end
            @(negedge clk); #1;
            chk1({tag, "_rvalid"}, is_ls ? ls_rvalid : if_rvalid, 1'b1);
            chk1({tag, "_other_rvalid"}, is_ls ? if_rvalid : ls_rvalid, 1'b0);
            chk({tag, "_rdata"}, is_ls ? ls_rdata : if_rdata, rd);
        end
    endtask

    typedef struct {
        string       name;
        logic        is_ls;
        logic        we;
        logic [3:0]  addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } vec_t;

    vec_t vt[9];

    // Reference model state for the random phase.
    logic [63:0] ref_mem [16];
    bit          en_s   [NS];
    bit          en_we  [NS];
    logic [3:0]  en_addr[NS];
    logic [63:0] en_wd  [NS];
    int          rv_who [NS];
    logic [63:0] rv_dat [NS];

    int   gcyc[$];
    bit   gls[$];
    bit   exp_order[$];

    initial begin
        // Reset state, with both requests high to show grants are held off.
        #2 rst = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        #1 chk_reset_outputs("reset0");
        @(negedge clk); @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;

        // Directed vectors, back to back from IDLE.
        vt[0] = '{"if_rd3",  1'b0, 1'b0, 4'd3,  64'd0,      64'hA5};
        vt[1] = '{"ls_wr7",  1'b1, 1'b1, 4'd7,  64'h1234,   64'd0};
        vt[2] = '{"ls_rd7",  1'b1, 1'b0, 4'd7,  64'd0,      64'h1234};
        vt[3] = '{"ls_wr0",  1'b1, 1'b1, 4'd0,  {64{1'b1}}, 64'd0};
        vt[4] = '{"if_rd0",  1'b0, 1'b0, 4'd0,  64'd0,      {64{1'b1}}};
        vt[5] = '{"ls_rd15", 1'b1, 1'b0, 4'd15, 64'd0,      64'h100F};
        vt[6] = '{"if_rd15", 1'b0, 1'b0, 4'd15, 64'd0,      64'h100F};
        vt[7] = '{"ls_wr15", 1'b1, 1'b1, 4'd15, 64'hCAFE,   64'd0};
        vt[8] = '{"ls_rd15b",1'b1, 1'b0, 4'd15, 64'd0,      64'hCAFE};
        for (int i = 0; i < 9; i++)
            do_txn(vt[i].name, vt[i].is_ls, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata);

        // Contention: both requesters present in IDLE.
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b0};
`endif
        begin
            bit drop_ls = 1'b0;
            for (int c = 0; c < 80 && gls.size() < exp_order.size(); c++) begin
                @(negedge clk);
                if (drop_ls) ls_req = 1'b0;
                if (c == 0) begin
                    if_req = 1'b1; if_addr = 4'd3;
                    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 4'd7;
                end
                #1;
                chk1("arb_one_gnt", if_gnt & ls_gnt, 1'b0);
                if (ls_gnt) begin
                    gls.push_back(1'b1); gcyc.push_back(c);
`ifndef MEM_ARB_RR_EN
                    drop_ls = 1'b1;
`endif
                end else if (if_gnt) begin
                    gls.push_back(1'b0); gcyc.push_back(c);
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        chk("arb_grant_count", 64'(gls.size()), 64'(exp_order.size()));
        for (int i = 0; i < gls.size() && i < exp_order.size(); i++) begin
            chk1("arb_order", gls[i], exp_order[i]);
            if (i > 0) chk("arb_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(3 + LAT));
        end
        repeat (LAT + 4) @(negedge clk);

        // Reset asserted while waiting on read data.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 4'd5;
        #1 chk1("rstw_gnt", ls_gnt, 1'b1);
        @(negedge clk);
        ls_req = 1'b0;
        #1 chk1("rstw_en", mem_en, 1'b1);
        @(negedge clk);
        #1 chk1("rstw_busy_wait", busy, 1'b1);
        if_req = 1'b1; ls_req = 1'b1; rst = 1'b0;
        #1 chk_reset_outputs("rstw");
        @(negedge clk); @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk); #1;
            chk1("rstw_no_rvalid", if_rvalid | ls_rvalid, 1'b0);
            chk1("rstw_no_en", mem_en, 1'b0);
            chk1("rstw_idle", busy, 1'b0);
        end
        do_txn("post_rst", 1'b0, 1'b0, 4'd3, 64'd0, 64'hA5);

        // Fetch request raised while busy and withdrawn before IDLE.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 4'd1;
        #1 chk1("pulse_ls_gnt", ls_gnt, 1'b1);
        @(negedge clk);
        ls_req = 1'b0; if_req = 1'b1; if_addr = 4'd9;
        #1;
        chk1("pulse_en", mem_en, 1'b1);
        chk1("pulse_if_gnt_busy", if_gnt, 1'b0);
        begin
            int sneak = 0;
            for (int k = 2; k <= 8; k++) begin
                @(negedge clk);
                if (k == 2 + LAT) if_req = 1'b0;
                #1;
                sneak += int'(if_gnt) + int'(mem_en);
                if (k == 2 + LAT) begin
                    chk1("pulse_ls_rvalid", ls_rvalid, 1'b1);
                    chk1("pulse_if_rvalid", if_rvalid, 1'b0);
                    chk("pulse_ls_rdata", ls_rdata, 64'h1001);
                end
            end
            chk("pulse_no_access", 64'(sneak), 64'd0);
        end

        // Random traffic against the transaction-timing model.
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = dev_mem[i];
        for (int i = 0; i < NS; i++) begin
            en_s[i] = 1'b0; en_we[i] = 1'b0; en_addr[i] = '0; en_wd[i] = '0;
            rv_who[i] = 0; rv_dat[i] = '0;
        end
        begin
            int          free_at = 0;
            bit          last_ls = 1'b0;
            bit          ifr_on = 1'b0, lsr_on = 1'b0, lsr_we = 1'b0;
            logic [3:0]  ifr_addr = '0, lsr_addr = '0;
            logic [63:0] lsr_wdata = '0;
            bit          exp_g, win_ls;
            for (int c = 0; c < NR; c++) begin
                @(negedge clk);
                if (!ifr_on) begin
                    if ($urandom_range(0, 2) == 0) begin
                        ifr_on = 1'b1; ifr_addr = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    ifr_on = 1'b0;
                end
                if (!lsr_on) begin
                    if ($urandom_range(0, 2) == 0) begin
                        lsr_on = 1'b1; lsr_we = 1'($urandom_range(0, 1));
                        lsr_addr = 4'($urandom_range(0, 15)); lsr_wdata = {$urandom, $urandom};
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    lsr_on = 1'b0;
                end
                if_req = ifr_on; if_addr = ifr_addr;
                ls_req = lsr_on; ls_we = lsr_we; ls_addr = lsr_addr; ls_wdata = lsr_wdata;
                #1;
                exp_g = (c >= free_at) && (ifr_on || lsr_on);
`ifdef MEM_ARB_RR_EN
                win_ls = lsr_on && (!ifr_on || !last_ls);
`else
                win_ls = lsr_on;
`endif
                chk1("rnd_if_gnt", if_gnt, exp_g && !win_ls);
                chk1("rnd_ls_gnt", ls_gnt, exp_g && win_ls);
                chk1("rnd_busy", busy, c < free_at);
                chk1("rnd_mem_en", mem_en, en_s[c]);
                if (en_s[c]) begin
                    chk1("rnd_mem_we", mem_we, en_we[c]);
                    chk("rnd_mem_addr", 64'(mem_addr), 64'(en_addr[c]));
                    if (en_we[c]) chk("rnd_mem_wdata", mem_wdata, en_wd[c]);
                end
                chk1("rnd_if_rvalid", if_rvalid, rv_who[c] == 1);
                chk1("rnd_ls_rvalid", ls_rvalid, rv_who[c] == 2);
                if (rv_who[c] == 1) chk("rnd_if_rdata", if_rdata, rv_dat[c]);
                if (rv_who[c] == 2) chk("rnd_ls_rdata", ls_rdata, rv_dat[c]);
                if (exp_g) begin
                    en_s[c+1]    = 1'b1;
                    en_we[c+1]   = win_ls && lsr_we;
                    en_addr[c+1] = win_ls ? lsr_addr : ifr_addr;
                    en_wd[c+1]   = lsr_wdata;
                    if (win_ls && lsr_we) begin
                        ref_mem[lsr_addr] = lsr_wdata;
                        free_at = c + 2;
                    end else begin
                        rv_who[c+2+LAT] = win_ls ? 2 : 1;
                        rv_dat[c+2+LAT] = ref_mem[win_ls ? lsr_addr : ifr_addr];
                        free_at = c + 3 + LAT;
                    end
                    last_ls = win_ls;
                    if (win_ls) lsr_on = 1'b0; else ifr_on = 1'b0;
                end
            end
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter Bits, default 64: data word width.
REQ-002 SHALL have parameter MemSize, default 16: memory depth in words (power of 2, >=2); AW = $clog2(MemSize).
REQ-003 SHALL have parameter MemLat, default 2: memory read latency in cycles (1..4).
REQ-004 SHALL have port clk  in  1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports if_req in 1, if_addr in AW: instruction-fetch read request and address.
REQ-007 SHALL have ports if_gnt out 1, if_rvalid out 1, if_rdata out Bits: fetch grant, read-data valid, read data.
REQ-008 SHALL have ports ls_req in 1, ls_we in 1, ls_addr in AW, ls_wdata in Bits: load/store request, write enable, address, write data.
REQ-009 SHALL have ports ls_gnt out 1, ls_rvalid out 1, ls_rdata out Bits: load/store grant, read-data valid, read data.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out Bits, mem_rdata in Bits: single shared memory port.
REQ-011 SHALL have port busy out 1: high whenever state != IDLE.

Function
REQ-012 SHALL implement FSM IDLE, ACCESS, WAIT, RESP.
REQ-013 IDLE with any req: assert the winner's gnt combinationally for that cycle only, capture winner id/we/addr/wdata, go to ACCESS.
REQ-014 IDLE with no req: remain IDLE, all gnt low.
REQ-015 ACCESS: drive mem_en=1 and mem_we/addr/wdata from the captured registers for exactly one cycle; write -> IDLE, read -> WAIT.
REQ-016 WAIT: load counter with MemLat-1 on entry, decrement each cycle; at 0, capture mem_rdata into rdata_q and go to RESP.
REQ-017 RESP: assert rvalid of the captured requester for one cycle, then go to IDLE.
REQ-018 Timing: gnt at cycle T; mem_en at T+1; read rvalid at T+2+MemLat; after a write, next gnt possible at T+2.
REQ-019 if_rdata and ls_rdata SHALL both present rdata_q; contents meaningful only while the matching rvalid is high.
REQ-020 Fetch requests are always reads; ls_we=1 yields a write with no rvalid.
REQ-021 Requesters hold req and fields stable until gnt; a req dropped before gnt is withdrawn with no memory access.
REQ-022 Requests arriving while busy SHALL wait; no queueing beyond the held req.
REQ-023 At most one gnt and one rvalid high in any cycle; mem_en never high outside ACCESS.

Reset
REQ-024 rst low SHALL force IDLE immediately, with gnt, rvalid, mem_en, mem_we, and busy at 0, and mem_addr, mem_wdata, rdata_q, counter, and last-grant register at 0.
REQ-025 Reset during ACCESS/WAIT/RESP SHALL abort the access; no rvalid is produced for it after release.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin arbitration; when both req in IDLE, grant the requester not granted last; last-grant resets to fetch, so load/store wins first.
REQ-027 Macro undefined: fixed priority, load/store over fetch; no last-grant register.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, requester-id enum (REQ_IF, REQ_LS), and default parameter constants.
REQ-029 Sub-module mem_lat_counter SHALL implement the WAIT latency down-counter (load, decrement, zero flag).

Verification
REQ-030 Fetch read, addr 3 holding 0xA5, MemLat=2: if_gnt at T, mem_en at T+1, if_rvalid with if_rdata=0xA5 at T+4.
REQ-031 LS write addr 7 data 0x1234, then LS read addr 7: second gnt at T+2; ls_rvalid with 0x1234; no rvalid for the write.
REQ-032 Both req asserted in IDLE, held: without macro, ls granted first and fetch after completion; with MEM_ARB_RR_EN, alternating grants ls, if, ls, if.
REQ-033 rst low during WAIT: outputs 0 asynchronously; after release, no rvalid; next request is served normally.
REQ-034 if_req pulsed while busy and dropped before IDLE: no if_gnt, no mem_en for that request.
